wb_sram_bridge: RTL and testbench
=================================

# wb_sram_bridge

Parametrised Wishbone-slave bridge between the Caravel management-core bus and `NUM_BANKS` OpenRAM-style single-port SRAM macros. Decodes one 1 MiB window per bank, drives registered active-low chip/write selects, byte write masks, address and data, waits a configurable read latency, and returns a single-cycle ack. Successor to the fixed two-bank glue: adds per-bank read-only protection, byte masking, configurable latency, master-abort handling and a violation-count status register.

## Interface

- `NUM_BANKS`, 4, SRAM banks (1..8)
- `ADDR_W`, 8, SRAM word-address width
- `READ_LAT`, 1, cycles from SRAM capture edge to valid `dout` (1..4)
- `BASE_HI`, 12'h300, `wbs_adr_i[31:20]` of bank 0; bank b at `BASE_HI+b`
- `RO_MASK`, 4'b0000, bit b set: bank b is read-only
- `STAT_ADDR`, 32'h3080_0004, status register address

- `wb_clk_i` in 1 bus clock; the only clock
- `wb_rst_ni` in 1 asynchronous, active-low reset
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each, Wishbone controls
- `wbs_sel_i` in 4 byte selects
- `wbs_adr_i` in 32 byte address
- `wbs_dat_i` in 32 write data
- `wbs_ack_o` out 1 single-cycle ack
- `wbs_dat_o` out 32 read data, valid while ack high
- `sram_csb_o` out NUM_BANKS active-low chip select per bank
- `sram_web_o` out 1 active-low write enable (shared)
- `sram_wmask_o` out 4 byte write mask (shared)
- `sram_addr_o` out ADDR_W word address `wbs_adr_i[ADDR_W+1:2]`
- `sram_din_o` out 32 write data
- `sram_dout_i` in 32*NUM_BANKS read data, bank b at `[32b+31:32b]`

## Operation

- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE: request = `cyc & stb`. Classify:
  - bank hit (`adr[31:20]==BASE_HI+b`, b<NUM_BANKS), read or write to writable bank: register csb/web/wmask/addr/din -> ACCESS.
  - write to RO bank, unmapped address, or `STAT_ADDR`: no SRAM activity -> ACK directly. RO writes and unmapped accesses increment violation counter; unmapped reads return 0.
- ACCESS (1 cycle): `sram_csb_o[b]=0`; write: `sram_web_o=0`, `sram_wmask_o=wbs_sel_i`. Macro captures at end of cycle. Write -> ACK; read -> WAIT.
- WAIT: READ_LAT cycles; last cycle registers `sram_dout_i[b]` into read-data reg -> ACK.
- ACK (1 cycle): `wbs_ack_o=1`, `wbs_dat_o`=read-data reg (0 for writes) -> IDLE. Request is never re-accepted in the ACK cycle.
- Master abort: `wbs_cyc_i` low in ACCESS or WAIT: SRAM cycle completes, ack suppressed, return to IDLE after the current state.
- Status read: `{viol_cnt[15:0], 8'h00, NUM_BANKS[7:0]}`. Status write (any data/sel): clears `viol_cnt`; takes priority over nothing else (counter cannot increment same cycle).
- `viol_cnt`: 16-bit, saturates at 16'hFFFF.

## Timing

- Reset (async assert, sync release): state IDLE, `sram_csb_o` all 1, `sram_web_o=1`, `sram_wmask_o=0`, `sram_addr_o=0`, `sram_din_o=0`, `wbs_ack_o=0`, `wbs_dat_o=0`, `viol_cnt=0`. Reset mid-access aborts without ack.
- All outputs registered; csb/web high outside ACCESS.
- Latency, request first seen in cycle T0: SRAM write ack at T2; SRAM read ack at T2+READ_LAT; status/RO/unmapped ack at T1.
- Back-to-back: next request may be accepted in cycle after ACK.

## Test plan

- Write 0xDEADBEEF to 0x3010_0010, sel=4'hF -> bank1 csb low one cycle, addr=4, web=0, ack at T2; read back -> dout captured, ack at T3 (READ_LAT=1), data 0xDEADBEEF.
- Byte write sel=4'b0010 to bank0 -> `sram_wmask_o=4'b0010` during ACCESS only.
- RO_MASK=4'b0100, write to 0x3020_0000 -> no csb activity, ack at T1, status read returns 0x0001_0004.
- Read 0x3050_0000 (NUM_BANKS=4) -> ack at T1, data 0, `viol_cnt` increments; write STAT_ADDR -> counter 0.
- Drop `wbs_cyc_i` during WAIT -> no ack, FSM IDLE, next request served normally.
- Assert `wb_rst_ni` low during ACCESS -> csb all 1 immediately, no ack; READ_LAT=3 sweep gives read ack at T5.

Source files
------------

// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge
// Wishbone slave that maps NUM_BANKS single-port SRAM macros into 1 MiB windows
// starting at BASE_HI (address bits [31:20]). It also provides one status register
// at STAT_ADDR that holds a saturating count of protection/decode violations.
//
// Ports
//   wb_clk_i, wb_rst_ni    bus clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i   Wishbone request controls
//   wbs_sel_i              byte selects, used as the SRAM write mask
//   wbs_adr_i              byte address
//   wbs_dat_i              write data
//   wbs_ack_o              single-cycle acknowledge
//   wbs_dat_o              read data, valid while ack is high
//   sram_csb_o             active-low chip select, one per bank
//   sram_web_o             shared active-low write enable
//   sram_wmask_o           shared byte write mask
//   sram_addr_o            SRAM word address
//   sram_din_o             SRAM write data
//   sram_dout_i            SRAM read data, bank b at [32b+31:32b]
module wb_sram_bridge #(
  parameter int                   NUM_BANKS = 4,
  parameter int                   ADDR_W    = 8,
  parameter int                   READ_LAT  = 1,
  parameter logic [11:0]          BASE_HI   = 12'h300,
  parameter logic [NUM_BANKS-1:0] RO_MASK   = '0,
  parameter logic [31:0]          STAT_ADDR = 32'h3080_0004
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_BANKS-1:0]      sram_csb_o,
  output logic                      sram_web_o,
  output logic [3:0]                sram_wmask_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  output logic [31:0]               sram_din_o,
  input  logic [32*NUM_BANKS-1:0]   sram_dout_i
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q;
  logic                we_q;
  logic                abort_q;
  logic [1:0]          lat_q;
  logic [15:0]         viol_q;

  logic                req, is_stat, hit, ro_hit;
  logic                sram_go, viol_inc, stat_clr;
  logic [NUM_BANKS-1:0] bank_sel;
  logic [BANK_W-1:0]   hit_bank;
  logic [31:0]         rd_bank;
  logic [31:0]         ack_data;

  // Address decode and request classification. The status address is checked
  // first so it can never be mistaken for a bank window.
  always_comb begin
    req      = wbs_cyc_i & wbs_stb_i;
    is_stat  = (wbs_adr_i == STAT_ADDR);
    bank_sel = '0;
    hit_bank = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wbs_adr_i[31:20] == BASE_HI + 12'(b)) begin
        bank_sel[b] = 1'b1;
        hit_bank    = BANK_W'(b);
      end
    end
    hit      = (|bank_sel) & ~is_stat;
    ro_hit   = |(bank_sel & RO_MASK);
    sram_go  = req & hit & ~(wbs_we_i & ro_hit);
    viol_inc = req & ~is_stat & (~hit | (wbs_we_i & ro_hit));
    stat_clr = req & is_stat & wbs_we_i;
  end

  // Read-data select for the bank currently being accessed.
  always_comb begin
    rd_bank = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BANK_W'(b)) begin
        rd_bank = sram_dout_i[32*b +: 32];
      end
    end
  end

  // Next-state logic. ack_data is the value loaded into wbs_dat_o on entry to ACK.
  // A master abort lets the SRAM cycle finish but returns to IDLE instead of ACK.
  always_comb begin
    state_d  = state_q;
    ack_data = '0;
    case (state_q)
      IDLE: begin
        if (sram_go) begin
          state_d = ACCESS;
        end else if (req) begin
          state_d = ACK;
          if (is_stat && !wbs_we_i) begin
            ack_data = {viol_q, 8'h00, 8'(NUM_BANKS)};
          end
        end
      end
      ACCESS: begin
        if (!wbs_cyc_i)  state_d = IDLE;
        else if (we_q)   state_d = ACK;
        else             state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          if (abort_q || !wbs_cyc_i) begin
            state_d = IDLE;
          end else begin
            state_d  = ACK;
            ack_data = rd_bank;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Per-access bookkeeping: target bank, direction, latency countdown, abort flag
  // and the saturating violation counter (a status write wins over an increment).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bank_q  <= '0;
      we_q    <= 1'b0;
      lat_q   <= '0;
      abort_q <= 1'b0;
      viol_q  <= '0;
    end else begin
      if (state_q == IDLE && sram_go) begin
        bank_q <= hit_bank;
        we_q   <= wbs_we_i;
      end
      if (state_q == ACCESS) begin
        lat_q   <= 2'(READ_LAT - 1);
        abort_q <= 1'b0;
      end else if (state_q == WAIT) begin
        if (lat_q != 2'd0) lat_q <= lat_q - 2'd1;
        if (!wbs_cyc_i)    abort_q <= 1'b1;
      end
      if (state_q == IDLE) begin
        if (stat_clr)                           viol_q <= '0;
        else if (viol_inc && viol_q != 16'hFFFF) viol_q <= viol_q + 16'd1;
      end
    end
  end

  // Registered bus and SRAM outputs. Strobes are asserted only for the single
  // ACCESS cycle; address and write data hold their last value in between.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sram_csb_o   <= '1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
      sram_addr_o  <= '0;
      sram_din_o   <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
    end else begin
      sram_csb_o   <= '1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      if (state_q == IDLE && sram_go) begin
        sram_csb_o   <= ~bank_sel;
        sram_web_o   <= ~wbs_we_i;
        sram_wmask_o <= wbs_we_i ? wbs_sel_i : 4'h0;
        sram_addr_o  <= wbs_adr_i[ADDR_W+1:2];
        sram_din_o   <= wbs_dat_i;
      end
      if (state_d == ACK) begin
        wbs_ack_o <= 1'b1;
        wbs_dat_o <= ack_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Testbench for wb_sram_bridge. The main instance (READ_LAT=1, bank 2 read-only)
// is compared every cycle against a transaction-level model. A second instance
// with READ_LAT=3 gets a few directed latency/data checks.
module tb_wb_sram_bridge;

  localparam int         NB = 4;
  localparam int         AW = 8;
  localparam logic [3:0] RO = 4'b0100;
  localparam logic [31:0] STAT = 32'h3080_0004;

  logic clk = 1'b0;
  logic rst_n;

  logic           cyc, stb, we, ack, web;
  logic [3:0]     sel, wmask, csb;
  logic [31:0]    adr, dat, dat_o, sdin;
  logic [AW-1:0]  saddr;
  logic [32*NB-1:0] sdout;

  logic           bcyc, bstb, bwe, back, bweb;
  logic [3:0]     bsel, bwmask, bcsb;
  logic [31:0]    badr, bdat, bdat_o, bsdin;
  logic [AW-1:0]  bsaddr;
  logic [32*NB-1:0] bsdout;

  wb_sram_bridge #(.NUM_BANKS(NB), .ADDR_W(AW), .READ_LAT(1), .BASE_HI(12'h300),
                   .RO_MASK(RO), .STAT_ADDR(STAT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .sram_csb_o(csb), .sram_web_o(web), .sram_wmask_o(wmask),
    .sram_addr_o(saddr), .sram_din_o(sdin), .sram_dout_i(sdout));

  wb_sram_bridge #(.NUM_BANKS(NB), .ADDR_W(AW), .READ_LAT(3), .BASE_HI(12'h300),
                   .RO_MASK(4'b0000), .STAT_ADDR(STAT)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(bcyc), .wbs_stb_i(bstb), .wbs_we_i(bwe), .wbs_sel_i(bsel),
    .wbs_adr_i(badr), .wbs_dat_i(bdat), .wbs_ack_o(back), .wbs_dat_o(bdat_o),
    .sram_csb_o(bcsb), .sram_web_o(bweb), .sram_wmask_o(bwmask),
    .sram_addr_o(bsaddr), .sram_din_o(bsdin), .sram_dout_i(bsdout));

  always #5 clk = ~clk;

  // Cycle index: value k holds from posedge k until posedge k+1.
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int passed = 0;

  function automatic logic [31:0] init_word(input int b, input int a);
    return 32'((b + 1) << 28) | 32'(a * 32'h0001_0101);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, want);
  endtask

  // SRAM macro models: write on the capture edge, read data appears READ_LAT
  // cycles later for exactly one cycle, garbage otherwise.
  logic [31:0] mem  [NB][256];
  logic [31:0] memb [NB][256];
  logic [31:0] pipe [NB];
  logic [31:0] pipeb [NB][3];
  bit mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 256; a++) begin
          mem[b][a]  <= init_word(b, a);
          memb[b][a] <= init_word(b, a);
        end
      mem_init <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (!csb[b] && !web && wmask[k])      mem[b][saddr][8*k +: 8]   <= sdin[8*k +: 8];
          if (!bcsb[b] && !bweb && bwmask[k])  memb[b][bsaddr][8*k +: 8] <= bsdin[8*k +: 8];
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      pipe[b]     <= (!csb[b] && web)   ? mem[b][saddr]   : (32'hBAD0_0000 | 32'(b));
      pipeb[b][0] <= (!bcsb[b] && bweb) ? memb[b][bsaddr] : (32'hBAD1_0000 | 32'(b));
      pipeb[b][1] <= pipeb[b][0];
      pipeb[b][2] <= pipeb[b][1];
    end
  end

  assign sdout  = {pipe[3], pipe[2], pipe[1], pipe[0]};
  assign bsdout = {pipeb[3][2], pipeb[2][2], pipeb[1][2], pipeb[0][2]};

  // Expected outputs per cycle, filled in by the model when a request is issued.
  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        access;
    logic [3:0]  csb;
    logic        web;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din;
  } exp_t;

  exp_t exp_at [int];
  logic [31:0] ref_mem [NB][256];
  int ref_viol = 0;

  function automatic exp_t idle_exp();
    exp_t e;
    e.ack = 1'b0; e.data = '0; e.access = 1'b0; e.csb = 4'hF;
    e.web = 1'b1; e.wmask = 4'h0; e.addr = '0; e.din = '0;
    return e;
  endfunction

  // Every-cycle compare of the main instance against the model (or reset values).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkOutput($sformatf("c%0d rst ack", cyc_n), 32'(ack), 32'h0);
      checkOutput($sformatf("c%0d rst csb", cyc_n), 32'(csb), 32'hF);
      checkOutput($sformatf("c%0d rst web", cyc_n), 32'(web), 32'h1);
      checkOutput($sformatf("c%0d rst wmask", cyc_n), 32'(wmask), 32'h0);
      checkOutput($sformatf("c%0d rst addr", cyc_n), 32'(saddr), 32'h0);
      checkOutput($sformatf("c%0d rst din", cyc_n), sdin, 32'h0);
      checkOutput($sformatf("c%0d rst dat_o", cyc_n), dat_o, 32'h0);
    end else if (mem_init) begin
      e = exp_at.exists(cyc_n) ? exp_at[cyc_n] : idle_exp();
      checkOutput($sformatf("c%0d ack", cyc_n), 32'(ack), 32'(e.ack));
      checkOutput($sformatf("c%0d csb", cyc_n), 32'(csb), 32'(e.csb));
      checkOutput($sformatf("c%0d web", cyc_n), 32'(web), 32'(e.web));
      checkOutput($sformatf("c%0d wmask", cyc_n), 32'(wmask), 32'(e.wmask));
      if (e.ack) checkOutput($sformatf("c%0d dat_o", cyc_n), dat_o, e.data);
      if (e.access) begin
        checkOutput($sformatf("c%0d addr", cyc_n), 32'(saddr), 32'(e.addr));
        checkOutput($sformatf("c%0d din", cyc_n), sdin, e.din);
      end
    end
  end

  // Issue one request on the main instance at the current cycle, record the
  // model's expectations, hold the bus until the expected ack cycle and release
  // it the cycle after. Returns the observed ack latency and data.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] got_data,
                               output int got_lat);
    int t0, ack_at, bank;
    logic [7:0] wa;
    logic [31:0] want;
    logic is_stat, mapped;
    exp_t e;
    t0      = cyc_n;
    bank    = int'(a[31:20]) - 'h300;
    wa      = a[9:2];
    is_stat = (a == STAT);
    mapped  = !is_stat && bank >= 0 && bank < NB;
    want    = '0;
    if (is_stat) begin
      ack_at = t0 + 1;
      if (w) ref_viol = 0;
      else   want = {ref_viol[15:0], 8'h00, 8'd4};
    end else if (!mapped || (w && RO[bank])) begin
      ack_at = t0 + 1;
      if (ref_viol < 65535) ref_viol++;
    end else begin
      e = idle_exp();
      e.access = 1'b1;
      e.csb    = 4'hF & ~(4'b0001 << bank);
      e.web    = ~w;
      e.wmask  = w ? s : 4'h0;
      e.addr   = wa;
      e.din    = d;
      exp_at[t0 + 1] = e;
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) ref_mem[bank][wa][8*k +: 8] = d[8*k +: 8];
        ack_at = t0 + 2;
      end else begin
        want   = ref_mem[bank][wa];
        ack_at = t0 + 3;
      end
    end
    e = idle_exp();
    e.ack  = 1'b1;
    e.data = want;
    exp_at[ack_at] = e;

    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    got_lat = -1;
    got_data = '0;
    repeat (ack_at - t0) begin
      @(posedge clk); #1;
      if (ack && got_lat < 0) begin
        got_lat  = cyc_n - t0;
        got_data = dat_o;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // One request on the READ_LAT=3 instance, waiting at most 10 cycles for ack.
  task automatic busOpB(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] got_data, output int got_lat);
    bcyc = 1'b1; bstb = 1'b1; bwe = w; badr = a; bdat = d; bsel = s;
    got_lat = -1;
    got_data = '0;
    for (int i = 1; i <= 10 && got_lat < 0; i++) begin
      @(posedge clk); #1;
      if (back) begin
        got_lat  = i;
        got_data = bdat_o;
      end
    end
    @(posedge clk); #1;
    bcyc = 1'b0; bstb = 1'b0; bwe = 1'b0;
  endtask

  logic [31:0] bb_adr [4] = '{32'h3000_0004, 32'h3010_0008, 32'h3030_000C, 32'h3000_0004};
  logic [31:0] bb_dat [4] = '{32'hA1B2_C3D4, 32'h0BAD_F00D, 32'h1357_9BDF, 32'hFFEE_DDCC};
  logic [3:0]  bb_sel [4] = '{4'hF, 4'b1001, 4'b0100, 4'b0110};

  initial begin
    logic [31:0] d;
    int lat;
    int acks;
    exp_t e;

    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
    bcyc = 0; bstb = 0; bwe = 0; bsel = 0; badr = 0; bdat = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) ref_mem[b][a] = init_word(b, a);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back on bank 1
    applyStimulus(1'b1, 32'h3010_0010, 32'hDEAD_BEEF, 4'hF, d, lat);
    checkOutput("wr latency", 32'(lat), 32'd2);
    applyStimulus(1'b0, 32'h3010_0010, 32'h0, 4'hF, d, lat);
    checkOutput("rd latency", 32'(lat), 32'd3);
    checkOutput("rd data", d, 32'hDEAD_BEEF);

    // Byte write on bank 0 only touches byte 1
    applyStimulus(1'b1, 32'h3000_0020, 32'h1122_3344, 4'b0010, d, lat);
    applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF, d, lat);
    checkOutput("byte merge", d, 32'h1008_3308);

    // Top word of bank 3, untouched contents
    applyStimulus(1'b0, 32'h3030_03FC, 32'h0, 4'hF, d, lat);
    checkOutput("bank3 top", d, 32'h40FF_FFFF);

    // Write to read-only bank 2: direct ack, no SRAM activity, one violation
    applyStimulus(1'b1, 32'h3020_0000, 32'h5555_AAAA, 4'hF, d, lat);
    checkOutput("ro wr latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, STAT, 32'h0, 4'hF, d, lat);
    checkOutput("stat after ro", d, 32'h0001_0004);
    checkOutput("stat latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, 32'h3020_0000, 32'h0, 4'hF, d, lat);
    checkOutput("ro bank read", d, 32'h3000_0000);

    // Unmapped read, then status clear
    applyStimulus(1'b0, 32'h3050_0000, 32'h0, 4'hF, d, lat);
    checkOutput("unmapped latency", 32'(lat), 32'd1);
    checkOutput("unmapped data", d, 32'h0);
    applyStimulus(1'b0, STAT, 32'h0, 4'hF, d, lat);
    checkOutput("stat after unmapped", d, 32'h0002_0004);
    applyStimulus(1'b1, STAT, 32'h1234_5678, 4'b0001, d, lat);
    applyStimulus(1'b0, STAT, 32'h0, 4'hF, d, lat);
    checkOutput("stat cleared", d, 32'h0000_0004);

    // Back-to-back writes with mixed masks, then read them all back
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, bb_adr[i], bb_dat[i], bb_sel[i], d, lat);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, bb_adr[i], 32'h0, 4'hF, d, lat);
    checkOutput("b2b merged", d, 32'hA1EE_DDD4);

    // Unmapped write counts as a violation
    applyStimulus(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, d, lat);
    applyStimulus(1'b0, STAT, 32'h0, 4'hF, d, lat);
    checkOutput("stat unmapped wr", d, 32'h0001_0004);

    // Master abort during WAIT: no ack, bridge returns to IDLE
    e = idle_exp();
    e.access = 1'b1; e.csb = 4'h7; e.addr = 8'd2; e.din = 32'h0;
    exp_at[cyc_n + 1] = e;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3030_0008; dat = 32'h0; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    checkOutput("abort acks", 32'(acks), 32'd0);
    applyStimulus(1'b0, 32'h3030_0008, 32'h0, 4'hF, d, lat);
    checkOutput("post abort latency", 32'(lat), 32'd3);
    checkOutput("post abort data", d, 32'h4002_0202);

    // Reset asserted during ACCESS: strobes drop at once, no ack, counter cleared
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    @(posedge clk); #1;
    checkOutput("pre-reset csb", 32'(csb), 32'hE);
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    #1;
    checkOutput("reset csb", 32'(csb), 32'hF);
    checkOutput("reset ack", 32'(ack), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_at.delete();
    ref_viol = 0;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b0, STAT, 32'h0, 4'hF, d, lat);
    checkOutput("stat after reset", d, 32'h0000_0004);

    // READ_LAT=3 instance
    busOpB(1'b1, 32'h3010_0010, 32'hDEAD_BEEF, 4'hF, d, lat);
    checkOutput("lat3 wr latency", 32'(lat), 32'd2);
    busOpB(1'b0, 32'h3010_0010, 32'h0, 4'hF, d, lat);
    checkOutput("lat3 rd latency", 32'(lat), 32'd5);
    checkOutput("lat3 rd data", d, 32'hDEAD_BEEF);
    busOpB(1'b0, 32'h3020_0008, 32'h0, 4'hF, d, lat);
    checkOutput("lat3 rd2 latency", 32'(lat), 32'd5);
    checkOutput("lat3 rd2 data", d, 32'h3002_0202);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
